// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline.
// It drives the EX forwarding selects, the pipeline latch enables, the flush/redirect controls and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ex_rs1_addr,
  input  logic [4:0]           ex_rs2_addr,
  input  logic                 ex_uses_rs1,
  input  logic                 ex_uses_rs2,
  input  logic                 ex_is_store,
  input  logic [4:0]           mem_rd_addr,
  input  logic                 mem_regwrite,
  input  logic                 mem_is_load,
  input  logic [4:0]           wb_rd_addr,
  input  logic                 wb_regwrite,
  input  logic                 br_mispredict,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  output logic [2:0]           forwardA,
  output logic [2:0]           forwardB,
  output logic                 pc_load,
  output logic                 if_id_load,
  output logic                 id_ex_load,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
  output logic                 pc_redirect,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int unsigned TW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TW-1:0]        r_timer;
  logic [TW-1:0]        w_timer_nxt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic w_mem_stall;
  logic w_fetch_stall;
  logic w_any_load_low;
  logic w_rs1_mem_hit;
  logic w_rs1_wb_hit;
  logic w_rs2_mem_hit;
  logic w_rs2_wb_hit;

  assign w_mem_stall   = dmem_req & ~dmem_resp;
  assign w_fetch_stall = ~imem_resp;

  // A MEM-stage load always writes rd, so it counts as a producer even without mem_regwrite.
  assign w_rs1_mem_hit = (ex_rs1_addr != 5'd0) && (ex_rs1_addr == mem_rd_addr)
                         && (mem_regwrite || mem_is_load);
  assign w_rs1_wb_hit  = (ex_rs1_addr != 5'd0) && (ex_rs1_addr == wb_rd_addr) && wb_regwrite;
  assign w_rs2_mem_hit = (ex_rs2_addr != 5'd0) && (ex_rs2_addr == mem_rd_addr)
                         && (mem_regwrite || mem_is_load);
  assign w_rs2_wb_hit  = (ex_rs2_addr != 5'd0) && (ex_rs2_addr == wb_rd_addr) && wb_regwrite;

  always_comb begin : fwd_select
    forwardA = 3'd0;
    forwardB = 3'd0;
    if (!reset && ex_uses_rs1) begin
      if (w_rs1_mem_hit)     forwardA = mem_is_load ? 3'd3 : 3'd2;
      else if (w_rs1_wb_hit) forwardA = 3'd1;
    end
    if (!reset && (ex_uses_rs2 || ex_is_store)) begin
      if (w_rs2_mem_hit)     forwardB = mem_is_load ? 3'd3 : 3'd2;
      else if (w_rs2_wb_hit) forwardB = ex_is_store ? 3'd4 : 3'd1;
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      r_state <= ST_RUN;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // RUN and DWAIT share the non-stalled decision, so a mispredict frozen during DWAIT is taken exactly once when memory releases.
  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    pc_load     = 1'b0;
    if_id_load  = 1'b0;
    id_ex_load  = 1'b0;
    ex_mem_load = 1'b0;
    mem_wb_load = 1'b0;
    pc_redirect = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_RUN, ST_DWAIT: begin
          if (w_mem_stall) begin
            w_state_nxt = ST_DWAIT;
          end else if (br_mispredict) begin
            pc_redirect = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_state_nxt = ST_FLUSH;
              w_timer_nxt = TW'(FLUSH_CYCLES - 1);
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else if (w_fetch_stall) begin
            flush_id_ex = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (!w_mem_stall) begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if (r_timer == TW'(1)) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_timer_nxt = r_timer - TW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  assign w_any_load_low = ~(pc_load & if_id_load & id_ex_load & ex_mem_load & mem_wb_load);

  // Saturating performance counters.
  always_ff @(posedge clk) begin : perf_cnt
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_any_load_low && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
      if (pc_redirect && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// It uses table-driven forwarding vectors plus hand-written stall, flush, reset and saturation sequences.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CNT_WIDTH    = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [4:0]           ex_rs1_addr, ex_rs2_addr, mem_rd_addr, wb_rd_addr;
  logic                 ex_uses_rs1, ex_uses_rs2, ex_is_store;
  logic                 mem_regwrite, mem_is_load, wb_regwrite;
  logic                 br_mispredict, imem_resp, dmem_req, dmem_resp;
  logic [2:0]           forwardA, forwardB;
  logic                 pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic                 pc_redirect, flush_if_id, flush_id_ex;
  logic [CNT_WIDTH-1:0] stall_cycles, flush_count;
  logic [4:0]           loads;
  logic [2:0]           ctl;

  int n_pass  = 0;
  int n_total = 0;
  int n_redir;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       st;
    logic [4:0] mrd;
    logic       mrw;
    logic       mld;
    logic [4:0] wrd;
    logic       wrw;
    int         fa;
    int         fb;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  assign loads = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load};
  assign ctl   = {pc_redirect, flush_if_id, flush_id_ex};

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_rs1_addr  (ex_rs1_addr),
    .ex_rs2_addr  (ex_rs2_addr),
    .ex_uses_rs1  (ex_uses_rs1),
    .ex_uses_rs2  (ex_uses_rs2),
    .ex_is_store  (ex_is_store),
    .mem_rd_addr  (mem_rd_addr),
    .mem_regwrite (mem_regwrite),
    .mem_is_load  (mem_is_load),
    .wb_rd_addr   (wb_rd_addr),
    .wb_regwrite  (wb_regwrite),
    .br_mispredict(br_mispredict),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_resp    (dmem_resp),
    .forwardA     (forwardA),
    .forwardB     (forwardB),
    .pc_load      (pc_load),
    .if_id_load   (if_id_load),
    .id_ex_load   (id_ex_load),
    .ex_mem_load  (ex_mem_load),
    .mem_wb_load  (mem_wb_load),
    .pc_redirect  (pc_redirect),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input vec_t v);
    ex_rs1_addr  = v.rs1;
    ex_rs2_addr  = v.rs2;
    ex_uses_rs1  = v.u1;
    ex_uses_rs2  = v.u2;
    ex_is_store  = v.st;
    mem_rd_addr  = v.mrd;
    mem_regwrite = v.mrw;
    mem_is_load  = v.mld;
    wb_rd_addr   = v.wrd;
    wb_regwrite  = v.wrw;
  endtask

  task automatic set_ctrl(input logic mis, input logic imem, input logic req, input logic resp);
    br_mispredict = mis;
    imem_resp     = imem;
    dmem_req      = req;
    dmem_resp     = resp;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    //          rs1    rs2    u1    u2    st    mrd    mrw   mld   wrd    wrw   fa fb
    vecs[0]  = '{5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 5'd9,  1'b1, 2, 2};
    vecs[1]  = '{5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 2, 2};
    vecs[2]  = '{5'd1,  5'd7,  1'b1, 1'b0, 1'b1, 5'd3,  1'b1, 1'b0, 5'd7,  1'b1, 0, 4};
    vecs[3]  = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 0, 0};
    vecs[4]  = '{5'd6,  5'd6,  1'b1, 1'b1, 1'b0, 5'd6,  1'b1, 1'b1, 5'd6,  1'b1, 3, 3};
    vecs[5]  = '{5'd8,  5'd8,  1'b1, 1'b1, 1'b0, 5'd2,  1'b1, 1'b0, 5'd8,  1'b1, 1, 1};
    vecs[6]  = '{5'd8,  5'd8,  1'b1, 1'b1, 1'b0, 5'd2,  1'b1, 1'b0, 5'd8,  1'b0, 0, 0};
    vecs[7]  = '{5'd5,  5'd5,  1'b0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 0, 0};
    vecs[8]  = '{5'd7,  5'd7,  1'b1, 1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 2, 2};
    vecs[9]  = '{5'd4,  5'd4,  1'b1, 1'b1, 1'b0, 5'd4,  1'b0, 1'b0, 5'd4,  1'b1, 1, 1};
    vecs[10] = '{5'd3,  5'd9,  1'b1, 1'b0, 1'b1, 5'd3,  1'b1, 1'b0, 5'd9,  1'b1, 2, 4};
    vecs[11] = '{5'd10, 5'd11, 1'b1, 1'b1, 1'b1, 5'd11, 1'b1, 1'b1, 5'd10, 1'b1, 1, 3};

    // Reset holds every control low and the forwarding selects at zero even with a live match.
    reset = 1'b1;
    set_fwd(vecs[0]);
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    sample();
    check("reset_loads", int'(loads), 0);
    check("reset_ctl", int'(ctl), 0);
    check("reset_fwdA", int'(forwardA), 0);
    check("reset_fwdB", int'(forwardB), 0);
    next_cycle();
    reset = 1'b0;
    sample();
    check("post_reset_loads", int'(loads), 31);
    check("post_reset_stall", int'(stall_cycles), 0);
    check("post_reset_flush", int'(flush_count), 0);

    // Forwarding table applied while the pipeline runs freely.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      set_fwd(vecs[i]);
      set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
      sample();
      check($sformatf("vec%0d_fwdA", i), int'(forwardA), vecs[i].fa);
      check($sformatf("vec%0d_fwdB", i), int'(forwardB), vecs[i].fb);
      check($sformatf("vec%0d_loads", i), int'(loads), 31);
    end

    // A load in MEM waits three cycles, then resolves with forwardA selecting mem_rdata.
    set_fwd(vecs[4]);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      set_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
      sample();
      check($sformatf("dwait%0d_loads", i), int'(loads), 0);
    end
    next_cycle();
    set_ctrl(1'b0, 1'b1, 1'b1, 1'b1);
    sample();
    check("dwait_resp_loads", int'(loads), 31);
    check("dwait_resp_fwdA", int'(forwardA), 3);
    next_cycle();
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    check("dwait_stall_cnt", int'(stall_cycles), 3);

    // A mispredict redirects for one cycle and flushes for two.
    next_cycle();
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    sample();
    check("mis_ctl0", int'(ctl), 7);
    check("mis_loads0", int'(loads), 31);
    next_cycle();
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    check("mis_ctl1", int'(ctl), 3);
    next_cycle();
    sample();
    check("mis_ctl2", int'(ctl), 0);
    check("mis_flush_cnt", int'(flush_count), 1);

    // A mispredict behind a memory stall is redirected exactly once after the stall clears.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      set_ctrl(1'b1, 1'b1, 1'b1, 1'b0);
      sample();
      check($sformatf("mis_stall%0d_redir", i), int'(pc_redirect), 0);
      check($sformatf("mis_stall%0d_loads", i), int'(loads), 0);
    end
    n_redir = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 0)      set_ctrl(1'b1, 1'b1, 1'b1, 1'b1);
      else if (i == 1) set_ctrl(1'b1, 1'b1, 1'b0, 1'b0);
      else             set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
      sample();
      n_redir += int'(pc_redirect);
    end
    check("mis_stall_redirects", n_redir, 1);
    check("mis_stall_flush_cnt", int'(flush_count), 2);
    check("mis_stall_stall_cnt", int'(stall_cycles), 5);

    // A fetch stall inserts a bubble into ID/EX while the back end drains.
    next_cycle();
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    check("fetch_loads", int'(loads), 5'b00111);
    check("fetch_ctl", int'(ctl), 1);

    // A memory stall outranks both a mispredict and a fetch stall.
    next_cycle();
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b0);
    sample();
    check("prio_stall_loads", int'(loads), 0);
    check("prio_stall_ctl", int'(ctl), 0);
    next_cycle();
    set_ctrl(1'b0, 1'b1, 1'b1, 1'b1);
    sample();
    check("prio_resp_loads", int'(loads), 31);

    // A mispredict outranks a fetch stall.
    next_cycle();
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    check("prio_mis_ctl", int'(ctl), 7);
    check("prio_mis_loads", int'(loads), 31);
    next_cycle();
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    check("prio_mis_flush", int'(ctl), 3);
    next_cycle();
    sample();
    check("prio_mis_done", int'(ctl), 0);

    // A memory stall during FLUSH freezes the flush timer.
    next_cycle();
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    sample();
    check("fstall_ctl0", int'(ctl), 7);
    next_cycle();
    set_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
    sample();
    check("fstall_loads", int'(loads), 0);
    check("fstall_redir", int'(pc_redirect), 0);
    next_cycle();
    set_ctrl(1'b0, 1'b1, 1'b1, 1'b1);
    sample();
    check("fstall_resume_ctl", int'(ctl), 3);
    check("fstall_resume_loads", int'(loads), 31);
    next_cycle();
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    check("fstall_done_ctl", int'(ctl), 0);
    check("fstall_stall_cnt", int'(stall_cycles), 8);
    check("fstall_flush_cnt", int'(flush_count), 4);

    // Reset in DWAIT abandons the wait and clears both counters.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      set_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
      sample();
    end
    next_cycle();
    reset = 1'b1;
    sample();
    check("rst_dwait_loads", int'(loads), 0);
    next_cycle();
    reset = 1'b0;
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    check("rst_dwait_after_loads", int'(loads), 31);
    check("rst_dwait_stall_cnt", int'(stall_cycles), 0);
    check("rst_dwait_flush_cnt", int'(flush_count), 0);

    // Both counters saturate at all-ones.
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    end
    next_cycle();
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    check("sat_stall_cnt", int'(stall_cycles), 15);
    for (int i = 0; i < 17; i++) begin
      next_cycle();
      set_ctrl(1'b1, 1'b1, 1'b0, 1'b0);
      next_cycle();
      set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    end
    next_cycle();
    sample();
    check("sat_flush_cnt", int'(flush_count), 15);
    check("sat_stall_hold", int'(stall_cycles), 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
